fp_mul_pipe: RTL and testbench
==============================

# fp_mul_pipe

Parametrised, pipelined IEEE-754 multiplier: the successor to the combinational single-precision multiplier in the floating-point datapath. Adds configurable exponent and mantissa widths, four rounding modes with correct guard/round/sticky rounding, exception flags, and a valid/ready streaming interface with backpressure. It sits between operand-fetch logic and the FP result/writeback path.

## Interface
- EXP_W, 8: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width; the significand is MAN_W+1 bits with the hidden bit.
- TAG_W, 4: width of the opaque sideband tag carried with each operation.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a, in_b  in  EXP_W+MAN_W+1 each  operands in IEEE layout {sign, exp, frac}.
- in_rm  in  2  rounding mode: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf).
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  EXP_W+MAN_W+1  packed product.
- out_flags  out  5  {invalid, div0 (always 0), overflow, underflow, inexact}.
- out_tag  out  TAG_W  tag of this result.

## Operation
- Three pipeline stages, each holding a valid bit.
- S1: unpack, classify (zero, inf, qNaN/sNaN, normal), compute sign = sa^sb and the signed exponent sum ea+eb-bias in EXP_W+2 bits. Subnormal inputs are treated as zero (DAZ) and keep their sign.
- S2: multiply the significands into a 2*(MAN_W+1)-bit product.
- S3: normalise.
  - If product MSB = 1: shift right 1 and exponent +1.
  - Extract guard, round and sticky (OR of all remaining bits).
  - Round per rm. RNE increments on G&(R|S|LSB). RUP/RDN increment when (G|R|S) is set and the sign matches the mode's direction.
  - A rounding carry-out renormalises and adds exponent +1.
- Special results, in priority order:
  - Any NaN input, or inf×0: canonical qNaN {0, all-ones, 1 followed by zeros}. invalid is set only for sNaN inputs or inf×0.
  - inf×finite or inf×inf: signed infinity, no flags.
  - zero×finite: signed zero, no flags.
- Overflow is biased exponent ≥ 2^EXP_W-1 after rounding. It sets overflow and inexact.
  - RNE: ±inf.
  - RTZ: ±max-finite.
  - RUP: +inf for positive results, -max-finite for negative.
  - RDN: the mirror of RUP.
- Underflow is biased exponent ≤ 0 after rounding. The result is flushed to signed zero (FTZ), and underflow and inexact are set.
- inexact is set whenever G|R|S is set on a finite result.

## Timing
- Latency is exactly 3 cycles from accept to out_valid when there is no stall. Throughput is 1 beat per cycle.
- Global enable: en = !out_valid | out_ready.
  - in_ready = en, combinational from out_ready.
  - All stages advance together when en = 1. A beat is accepted when in_valid & in_ready.
  - Bubbles are not squeezed out.
- While out_valid=1 and out_ready=0, every stage holds and out_result, out_flags and out_tag stay stable.
- in_valid=0 with en=1 inserts a bubble: S1 valid becomes 0.
- Reset: all stage valid bits are 0, out_valid=0, out_result=0, out_flags=0 and out_tag=0. in_ready=1 immediately after reset.
- Reset asserted mid-stream discards all in-flight beats. No partial result is emitted after release.
- Data registers update only when en=1. Valid bits reset asynchronously.

## Structure
- Shared package fp_pkg holds:
  - rounding-mode constants RM_RNE, RM_RTZ, RM_RUP, RM_RDN;
  - flag bit indices;
  - the class-encoding typedef;
  - functions returning bias, qNaN, inf and max-finite for a given EXP_W/MAN_W.
- One sub-module, fp_round_pack. It is combinational and takes sign, exponent, normalised significand, G/R/S and rm. It returns the packed result plus overflow, underflow and inexact, and is reusable by a future adder.

## Test plan
- 0x3FC00000 × 0x40000000, RNE -> 0x40400000, flags 0, out_valid exactly 3 cycles after accept.
- 0x3F800001 × 0x3F800001 -> RNE 0x3F800002 and RUP 0x3F800003, inexact=1 in both.
- 0x7F000000 × 0x40000000 -> RNE 0x7F800000, RTZ 0x7F7FFFFF, overflow=1, inexact=1; same operands with RDN and sign of a flipped -> 0xFF800000.
- 0x7F800000 × 0x00000000 -> 0x7FC00000, invalid=1. 0x00800000 × 0x3F000000 -> 0x00000000, underflow=1, inexact=1.
- Issue 4 back-to-back beats with tags 1..4, hold out_ready=0 for 5 cycles, then release -> in_ready=0 during the stall, outputs stable, all 4 results in order with no loss or duplication.
- Assert rst_n low with 2 beats in flight -> out_valid=0 at once, and no output after release until a new beat is accepted.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding modes, flag positions, operand
// classes and format constants derived from the exponent/fraction widths.
package fp_pkg;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  localparam int unsigned FLAG_NX = 0;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_NV = 4;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Format constants are returned zero-extended to 64 bits; callers keep the low
  // EXP_W+MAN_W+1 bits.
  function automatic logic [63:0] fp_inf(input int unsigned exp_w, input int unsigned man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fp_max_finite(input int unsigned exp_w, input int unsigned man_w);
    return (fp_inf(exp_w, man_w) - (64'd1 << man_w)) | ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Rounds a normalised significand with guard/round/sticky bits and packs it,
// handling overflow saturation and flush-to-zero on underflow.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  exponent,
  input  logic [MAN_W:0]           sig,
  input  logic                     g,
  input  logic                     r,
  input  logic                     s,
  input  logic [1:0]               rm,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     inexact
);

  localparam int unsigned XE    = EXP_W + 2;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned W     = EXP_W + MAN_W + 1;

  localparam logic [63:0] INF64  = fp_inf(EXP_W, MAN_W);
  localparam logic [63:0] MAXF64 = fp_max_finite(EXP_W, MAN_W);
  localparam logic signed [XE-1:0] EXP_OVF  = XE'((64'd1 << EXP_W) - 64'd1);
  localparam logic signed [XE-1:0] EXP_ZERO = '0;

  logic                 grs;
  logic                 inc;
  logic                 to_inf;
  logic [SIG_W:0]       sum;
  logic signed [XE-1:0] exp_r;

  always_comb begin
    grs    = g | r | s;
    inc    = 1'b0;
    to_inf = 1'b0;
    case (rm)
      RM_RNE: begin
        inc    = g & (r | s | sig[0]);
        to_inf = 1'b1;
      end
      RM_RUP: begin
        inc    = grs & ~sign;
        to_inf = ~sign;
      end
      RM_RDN: begin
        inc    = grs & sign;
        to_inf = sign;
      end
      default: ;
    endcase

    // A carry out leaves the fraction field all-zero, so only the exponent moves.
    sum       = {1'b0, sig} + {{SIG_W{1'b0}}, inc};
    exp_r     = exponent + {{(XE-1){1'b0}}, sum[SIG_W]};
    overflow  = exp_r >= EXP_OVF;
    underflow = exp_r <= EXP_ZERO;

    result  = {sign, exp_r[EXP_W-1:0], sum[MAN_W-1:0]};
    inexact = grs;
    if (overflow) begin
      result  = {sign, to_inf ? INF64[W-2:0] : MAXF64[W-2:0]};
      inexact = 1'b1;
    end else if (underflow) begin
      result  = {sign, {(W-1){1'b0}}};
      inexact = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier (DAZ/FTZ) with valid/ready
// streaming, a global stall enable and an opaque sideband tag.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [1:0]           in_rm,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [4:0]           out_flags,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned W     = EXP_W + MAN_W + 1;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned PW    = 2 * SIG_W;
  localparam int unsigned XE    = EXP_W + 2;

  localparam logic [63:0]   QNAN64 = fp_qnan(EXP_W, MAN_W);
  localparam logic [63:0]   INF64  = fp_inf(EXP_W, MAN_W);
  localparam logic [W-1:0]  QNAN   = QNAN64[W-1:0];
  localparam logic [XE-1:0] BIAS_X = XE'(fp_bias(EXP_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return CLS_ZERO;
    if (e != '1) return CLS_NORM;
    if (f == '0) return CLS_INF;
    return f[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
  endfunction

  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  // Stage 1 inputs
  fp_class_e            cls_a, cls_b;
  logic                 d1_sign, d1_spec, d1_nv, inf0;
  logic signed [XE-1:0] d1_exp;
  logic [W-1:0]         d1_spec_res;

  always_comb begin
    cls_a       = classify(in_a[W-2:MAN_W], in_a[MAN_W-1:0]);
    cls_b       = classify(in_b[W-2:MAN_W], in_b[MAN_W-1:0]);
    d1_sign     = in_a[W-1] ^ in_b[W-1];
    d1_exp      = {2'b00, in_a[W-2:MAN_W]} + {2'b00, in_b[W-2:MAN_W]} - BIAS_X;
    inf0        = (cls_a == CLS_INF && cls_b == CLS_ZERO) || (cls_a == CLS_ZERO && cls_b == CLS_INF);
    d1_spec     = 1'b1;
    d1_nv       = 1'b0;
    d1_spec_res = '0;
    if ((cls_a inside {CLS_QNAN, CLS_SNAN}) || (cls_b inside {CLS_QNAN, CLS_SNAN}) || inf0) begin
      d1_spec_res = QNAN;
      d1_nv       = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN) || inf0;
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      d1_spec_res = {d1_sign, INF64[W-2:0]};
    end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
      d1_spec_res = {d1_sign, {(W-1){1'b0}}};
    end else begin
      d1_spec = 1'b0;
    end
  end

  logic                 s1_valid, s1_sign, s1_spec, s1_nv;
  logic signed [XE-1:0] s1_exp;
  logic [SIG_W-1:0]     s1_siga, s1_sigb;
  logic [W-1:0]         s1_spec_res;
  logic [1:0]           s1_rm;
  logic [TAG_W-1:0]     s1_tag;

  logic                 s2_valid, s2_sign, s2_spec, s2_nv;
  logic signed [XE-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;
  logic [W-1:0]         s2_spec_res;
  logic [1:0]           s2_rm;
  logic [TAG_W-1:0]     s2_tag;

  // Stage 3: normalise the product so its leading one sits at the top bit
  logic [PW-1:0]        norm;
  logic signed [XE-1:0] n_exp;
  logic [W-1:0]         rp_result;
  logic                 rp_ovf, rp_unf, rp_nx;
  logic [4:0]           d3_flags;

  always_comb begin
    norm  = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
    n_exp = s2_exp + {{(XE-1){1'b0}}, s2_prod[PW-1]};
  end

  fp_round_pack #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round_pack (
    .sign     (s2_sign),
    .exponent (n_exp),
    .sig      (norm[PW-1 -: SIG_W]),
    .g        (norm[MAN_W]),
    .r        (norm[MAN_W-1]),
    .s        (|norm[MAN_W-2:0]),
    .rm       (s2_rm),
    .result   (rp_result),
    .overflow (rp_ovf),
    .underflow(rp_unf),
    .inexact  (rp_nx)
  );

  always_comb begin
    d3_flags = '0;
    if (s2_spec) begin
      d3_flags[FLAG_NV] = s2_nv;
    end else begin
      d3_flags[FLAG_OF] = rp_ovf;
      d3_flags[FLAG_UF] = rp_unf;
      d3_flags[FLAG_NX] = rp_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_spec     <= 1'b0;
      s1_nv       <= 1'b0;
      s1_exp      <= '0;
      s1_siga     <= '0;
      s1_sigb     <= '0;
      s1_spec_res <= '0;
      s1_rm       <= '0;
      s1_tag      <= '0;
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_spec     <= 1'b0;
      s2_nv       <= 1'b0;
      s2_exp      <= '0;
      s2_prod     <= '0;
      s2_spec_res <= '0;
      s2_rm       <= '0;
      s2_tag      <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_flags   <= '0;
      out_tag     <= '0;
    end else if (en) begin
      s1_valid    <= in_valid;
      s1_sign     <= d1_sign;
      s1_spec     <= d1_spec;
      s1_nv       <= d1_nv;
      s1_exp      <= d1_exp;
      s1_siga     <= {1'b1, in_a[MAN_W-1:0]};
      s1_sigb     <= {1'b1, in_b[MAN_W-1:0]};
      s1_spec_res <= d1_spec_res;
      s1_rm       <= in_rm;
      s1_tag      <= in_tag;
      s2_valid    <= s1_valid;
      s2_sign     <= s1_sign;
      s2_spec     <= s1_spec;
      s2_nv       <= s1_nv;
      s2_exp      <= s1_exp;
      s2_prod     <= {{SIG_W{1'b0}}, s1_siga} * {{SIG_W{1'b0}}, s1_sigb};
      s2_spec_res <= s1_spec_res;
      s2_rm       <= s1_rm;
      s2_tag      <= s1_tag;
      out_valid   <= s2_valid;
      out_result  <= s2_spec ? s2_spec_res : rp_result;
      out_flags   <= d3_flags;
      out_tag     <= s2_tag;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (single precision, 4-bit tag).
module tb_fp_mul_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_rm;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;
  logic [3:0]  out_tag;

  fp_mul_pipe #(
    .EXP_W(8),
    .MAN_W(23),
    .TAG_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rm     (in_rm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags),
    .out_tag   (out_tag)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drives one beat for one cycle and records its expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                      input logic [3:0] tag, input logic [31:0] res, input logic [4:0] flags);
    exp_t e;
    in_a = a; in_b = b; in_rm = rm; in_tag = tag; in_valid = 1'b1;
    e.res = res; e.flags = flags; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_rm = '0; in_tag = '0;
    #12;
    n_tests++;
    if ({out_valid, in_ready, out_result, out_flags, out_tag} !== {1'b0, 1'b1, 32'h0, 5'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b rdy=%b res=%h fl=%b tag=%h, want 0 1 0 0 0",
               out_valid, in_ready, out_result, out_flags, out_tag);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL after_reset: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    bit   got;
    int   lat;
    send(32'h3FC00000, 32'h40000000, 2'd0, 4'h5, 32'h40400000, 5'b00000);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, want 3", lat);
    end
    while (sb_q.size() != 0) begin
      wait_valid(got);
      e = sb_q.pop_front();
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL basic: timeout waiting for tag %h", e.tag);
      end else if ({out_result, out_flags, out_tag} !== {e.res, e.flags, e.tag}) begin
        n_fail++;
        $display("FAIL basic: got %h/%b/%h want %h/%b/%h", out_result, out_flags, out_tag, e.res, e.flags, e.tag);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rounding();
    exp_t e;
    bit   got;
    send(32'h3F800001, 32'h3F800001, 2'd0, 4'h1, 32'h3F800002, 5'b00001);
    send(32'h3F800001, 32'h3F800001, 2'd2, 4'h2, 32'h3F800003, 5'b00001);
    send(32'hFF000000, 32'h40000000, 2'd2, 4'h3, 32'hFF7FFFFF, 5'b00101);
    while (sb_q.size() != 0) begin
      wait_valid(got);
      e = sb_q.pop_front();
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL rounding: timeout waiting for tag %h", e.tag);
      end else if ({out_result, out_flags, out_tag} !== {e.res, e.flags, e.tag}) begin
        n_fail++;
        $display("FAIL rounding: got %h/%b/%h want %h/%b/%h", out_result, out_flags, out_tag, e.res, e.flags, e.tag);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    bit   got;
    send(32'h7F000000, 32'h40000000, 2'd0, 4'h4, 32'h7F800000, 5'b00101);
    send(32'h7F000000, 32'h40000000, 2'd1, 4'h5, 32'h7F7FFFFF, 5'b00101);
    send(32'hFF000000, 32'h40000000, 2'd3, 4'h6, 32'hFF800000, 5'b00101);
    while (sb_q.size() != 0) begin
      wait_valid(got);
      e = sb_q.pop_front();
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL overflow: timeout waiting for tag %h", e.tag);
      end else if ({out_result, out_flags, out_tag} !== {e.res, e.flags, e.tag}) begin
        n_fail++;
        $display("FAIL overflow: got %h/%b/%h want %h/%b/%h", out_result, out_flags, out_tag, e.res, e.flags, e.tag);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_specials();
    exp_t        e;
    bit          got;
    logic [31:0] ta [6] = '{32'h7F800000, 32'h00800000, 32'h7F800001, 32'h7FC00000, 32'hFF800000, 32'h80400000};
    logic [31:0] tb [6] = '{32'h00000000, 32'h3F000000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000};
    logic [31:0] tr [6] = '{32'h7FC00000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000};
    logic [4:0]  tf [6] = '{5'b10000, 5'b00011, 5'b10000, 5'b00000, 5'b00000, 5'b00000};
    for (int unsigned grp = 0; grp < 2; grp++) begin
      for (int unsigned i = 0; i < 3; i++)
        send(ta[grp*3+i], tb[grp*3+i], 2'd0, 4'(8 + grp*3 + i), tr[grp*3+i], tf[grp*3+i]);
      while (sb_q.size() != 0) begin
        wait_valid(got);
        e = sb_q.pop_front();
        n_tests++;
        if (!got) begin
          n_fail++;
          $display("FAIL specials: timeout waiting for tag %h", e.tag);
        end else if ({out_result, out_flags, out_tag} !== {e.res, e.flags, e.tag}) begin
          n_fail++;
          $display("FAIL specials: got %h/%b/%h want %h/%b/%h", out_result, out_flags, out_tag, e.res, e.flags, e.tag);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    bit          got;
    bit          seen;
    logic [31:0] ta [4] = '{32'h3FC00000, 32'h40000000, 32'h3FC00000, 32'hBF800000};
    logic [31:0] tb [4] = '{32'h40000000, 32'h40000000, 32'h3FC00000, 32'h40400000};
    logic [31:0] tr [4] = '{32'h40400000, 32'h40800000, 32'h40100000, 32'hC0400000};
    out_ready = 1'b0;
    // beats 1..3 enter while the output register is empty; beat 4 waits on the stall
    for (int unsigned i = 0; i < 4; i++) begin
      in_a = ta[i]; in_b = tb[i]; in_rm = 2'(i); in_tag = 4'(i + 1); in_valid = 1'b1;
      e.res = tr[i]; e.flags = 5'b00000; e.tag = 4'(i + 1);
      sb_q.push_back(e);
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if ({out_valid, in_ready, out_result, out_flags, out_tag} !== {1'b1, 1'b0, sb_q[0].res, sb_q[0].flags, sb_q[0].tag}) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d got v=%b rdy=%b %h/%b/%h want v=1 rdy=0 %h/%b/%h", c,
                 out_valid, in_ready, out_result, out_flags, out_tag, sb_q[0].res, sb_q[0].flags, sb_q[0].tag);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    while (sb_q.size() != 0) begin
      wait_valid(got);
      e = sb_q.pop_front();
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL back_to_back: timeout waiting for tag %h", e.tag);
      end else if ({out_result, out_flags, out_tag} !== {e.res, e.flags, e.tag}) begin
        n_fail++;
        $display("FAIL back_to_back: got %h/%b/%h want %h/%b/%h", out_result, out_flags, out_tag, e.res, e.flags, e.tag);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen |= out_valid;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_extra: got an extra result beat, want none");
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    bit   got;
    bit   seen;
    out_ready = 1'b0;
    send(32'h3FC00000, 32'h40000000, 2'd0, 4'hA, 32'h40400000, 5'b00000);
    send(32'h40000000, 32'h40000000, 2'd0, 4'hB, 32'h40800000, 5'b00000);
    send(32'h3FC00000, 32'h3FC00000, 2'd0, 4'hC, 32'h40100000, 5'b00000);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, in_ready, out_result, out_flags, out_tag} !== {1'b0, 1'b1, 32'h0, 5'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b rdy=%b res=%h fl=%b tag=%h, want 0 1 0 0 0",
               out_valid, in_ready, out_result, out_flags, out_tag);
    end
    sb_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seen |= out_valid;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: got out_valid=1 without a new beat, want 0");
    end
    send(32'hBF800000, 32'h40400000, 2'd1, 4'h7, 32'hC0400000, 5'b00000);
    while (sb_q.size() != 0) begin
      wait_valid(got);
      e = sb_q.pop_front();
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL post_reset: timeout waiting for tag %h", e.tag);
      end else if ({out_result, out_flags, out_tag} !== {e.res, e.flags, e.tag}) begin
        n_fail++;
        $display("FAIL post_reset: got %h/%b/%h want %h/%b/%h", out_result, out_flags, out_tag, e.res, e.flags, e.tag);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_specials();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
